fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RISC-V core. It holds the PC register, issues requests to instruction memory over a request/valid handshake, and loads the IF/ID pipeline register. It sits directly upstream of decode and consumes the hazard controls StallF, StallD, FlushD and PCSrcE. It absorbs variable memory latency by inserting bubbles into decode. A one-entry skid buffer holds a returned instruction while decode is stalled.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/if_id_reg.sv | 39 +++
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline: datapath width, bubble encoding
// and the fetch-stage state type.
package riscv_pkg;

    localparam int          XLEN_DEF  = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble load has priority over a normal enabled load;
// with neither asserted the register holds.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            bubble,
    input  logic [31:0]     instrIn,
    input  logic [XLEN-1:0] pcIn,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (bubble) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (en) begin
            InstrD   <= instrIn;
            PCD      <= pcIn;
            PCPlus4D <= pcIn + XLEN'(4);
            ValidD   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem request/valid handshake, one-entry skid
// buffer for decode stalls and discard of responses orphaned by a redirect.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic [31:0]     ImemRdata,
    input  logic            ImemValid,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic            FetchWaitF,
    output fetch_state_t    DbgStateF
);

    fetch_state_t    state, stateNext;
    logic [XLEN-1:0] pcF, pcNext, pcPlus4F, dropAddr;
    logic [31:0]     skidInstr;
    logic [XLEN-1:0] skidPc;
    logic            dropLoad, skidLoad, ifEn, ifBubble, ifFromSkid;

    assign pcPlus4F  = pcF + XLEN'(4);
    assign ImemReq   = (state != HOLD);
    assign ImemAddr  = (state == DROP) ? dropAddr : pcF;
    assign DbgStateF = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            pcF       <= RESET_PC;
            dropAddr  <= '0;
            skidInstr <= NOP_INSTR;
            skidPc    <= '0;
        end else begin
            state <= stateNext;
            pcF   <= pcNext;
            if (dropLoad) dropAddr <= pcF;
            if (skidLoad) begin
                skidInstr <= ImemRdata;
                skidPc    <= pcF;
            end
        end
    end

    // Redirect beats flush beats decode stall beats the memory response.
    always_comb begin
        stateNext  = state;
        pcNext     = pcF;
        dropLoad   = 1'b0;
        skidLoad   = 1'b0;
        ifEn       = 1'b0;
        ifBubble   = 1'b0;
        ifFromSkid = 1'b0;
        FetchWaitF = 1'b0;
        if (PCSrcE) begin
            pcNext   = PCTargetE;
            ifBubble = 1'b1;
            case (state)
                FETCH: if (!ImemValid) begin
                    dropLoad  = 1'b1;
                    stateNext = DROP;
                end
                HOLD:    stateNext = FETCH;
                DROP:    if (ImemValid) stateNext = FETCH;
                default: stateNext = FETCH;
            endcase
        end else if (FlushD) begin
            ifBubble = 1'b1;
            case (state)
                FETCH:   if (ImemValid && !StallF) pcNext = pcPlus4F;
                HOLD:    stateNext = FETCH;
                DROP:    if (ImemValid) stateNext = FETCH;
                default: stateNext = FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (ImemValid) begin
                        if (StallD) begin
                            skidLoad  = 1'b1;
                            pcNext    = pcPlus4F;
                            stateNext = HOLD;
                        end else begin
                            ifEn = 1'b1;
                            if (!StallF) pcNext = pcPlus4F;
                        end
                    end else if (!StallD) begin
                        ifBubble   = 1'b1;
                        FetchWaitF = rst;
                    end
                end
                HOLD: if (!StallD) begin
                    ifEn       = 1'b1;
                    ifFromSkid = 1'b1;
                    stateNext  = FETCH;
                end
                DROP: begin
                    if (ImemValid) stateNext = FETCH;
                    if (!StallD) ifBubble = 1'b1;
                end
                default: stateNext = FETCH;
            endcase
        end
    end

    if_id_reg #(.XLEN(XLEN)) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .en       (ifEn),
        .bubble   (ifBubble),
        .instrIn  (ifFromSkid ? skidInstr : ImemRdata),
        .pcIn     (ifFromSkid ? skidPc : pcF),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan steps followed by random stalls,
// redirects and memory latency, all checked against a transaction-level model.
module tb_fetch_stage;
    import riscv_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [31:0]  PCTargetE = '0;
    logic         ImemReq;
    logic [31:0]  ImemAddr;
    logic [31:0]  ImemRdata = '0;
    logic         ImemValid = 1'b0;
    logic [31:0]  InstrD, PCD, PCPlus4D;
    logic         ValidD, FetchWaitF;
    fetch_state_t dbgState;

    fetch_stage dut (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemRdata(ImemRdata), .ImemValid(ImemValid), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchWaitF(FetchWaitF), .DbgStateF(dbgState)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: program counter, whether a returned instruction is parked, whether
    // the outstanding request belongs to an abandoned path, and the IF/ID view.
    logic [31:0] mPc, mDropAddr, mSkidInstr, mSkidPc;
    logic        mSkidFull, mDropping;
    logic [31:0] mInstrD, mPcD, mPc4D;
    logic        mValidD;

    function automatic logic [31:0] instrAt(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h0050_0093;
        return (addr * 32'h0001_0001) ^ 32'h5A5A_0033;
    endfunction

    function automatic logic expReq();
        return !mSkidFull;
    endfunction

    function automatic logic [31:0] expAddr();
        return mDropping ? mDropAddr : mPc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPc = 32'h0; mDropAddr = 32'h0; mSkidFull = 1'b0; mDropping = 1'b0;
        mSkidInstr = NOP; mSkidPc = 32'h0;
        mInstrD = NOP; mPcD = 32'h0; mPc4D = 32'h0; mValidD = 1'b0;
    endtask

    task automatic bubble();
        mInstrD = NOP; mPcD = 32'h0; mPc4D = 32'h0; mValidD = 1'b0;
    endtask

    task automatic deliver(input logic [31:0] instr, input logic [31:0] pc);
        mInstrD = instr; mPcD = pc; mPc4D = pc + 32'd4; mValidD = 1'b1;
    endtask

    task automatic checkOutputs(input logic expWait);
        check("ImemReq", {31'b0, ImemReq}, {31'b0, expReq()});
        check("ImemAddr", ImemAddr, expAddr());
        check("InstrD", InstrD, mInstrD);
        check("PCD", PCD, mPcD);
        check("PCPlus4D", PCPlus4D, mPc4D);
        check("ValidD", {31'b0, ValidD}, {31'b0, mValidD});
        check("FetchWaitF", {31'b0, FetchWaitF}, {31'b0, expWait});
    endtask

    task automatic modelUpdate(input logic sF, input logic sD, input logic fD,
                               input logic pS, input logic [31:0] tgt, input logic v);
        logic [31:0] rd;
        rd = instrAt(expAddr());
        if (pS) begin
            bubble();
            if (mSkidFull) mSkidFull = 1'b0;
            else if (mDropping) begin
                if (v) mDropping = 1'b0;
            end else if (!v) begin
                mDropping = 1'b1;
                mDropAddr = mPc;
            end
            mPc = tgt;
        end else if (fD) begin
            bubble();
            mSkidFull = 1'b0;
            if (mDropping) begin
                if (v) mDropping = 1'b0;
            end else if (v && !sF) mPc = mPc + 32'd4;
        end else if (mSkidFull) begin
            if (!sD) begin
                deliver(mSkidInstr, mSkidPc);
                mSkidFull = 1'b0;
            end
        end else if (mDropping) begin
            if (v) mDropping = 1'b0;
            if (!sD) bubble();
        end else if (v) begin
            if (sD) begin
                mSkidInstr = rd; mSkidPc = mPc; mSkidFull = 1'b1;
                mPc = mPc + 32'd4;
            end else begin
                deliver(rd, mPc);
                if (!sF) mPc = mPc + 32'd4;
            end
        end else if (!sD) bubble();
    endtask

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic step(input logic sF, input logic sD, input logic fD, input logic pS,
                        input logic [31:0] tgt, input logic v);
        logic vv;
        logic expWait;
        vv = v && expReq();
        StallF = sF; StallD = sD; FlushD = fD; PCSrcE = pS; PCTargetE = tgt;
        ImemValid = vv;
        ImemRdata = vv ? instrAt(expAddr()) : 32'hDEAD_BEEF;
        expWait = expReq() && !mDropping && !vv && !sD && !fD && !pS;
        @(negedge clk);
        checkOutputs(expWait);
        modelUpdate(sF, sD, fD, pS, tgt, vv);
        @(posedge clk);
        #1;
    endtask

    int memWait;

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutputs(1'b0);
        rst = 1'b1;

        // Zero-wait memory out of reset.
        step(0, 0, 0, 0, 0, 1);
        check("rst_instr", InstrD, 32'h0050_0093);
        check("rst_pcd", PCD, 32'h0);
        check("rst_valid", {31'b0, ValidD}, 32'h1);
        check("rst_addr4", ImemAddr, 32'h4);
        step(0, 0, 0, 0, 0, 1);

        // Three-cycle wait at 0x8.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        check("wait_pcd", PCD, 32'h8);
        step(0, 0, 0, 0, 0, 1);

        // Decode stall while 0x10 returns.
        step(1, 1, 0, 0, 0, 1);
        check("hold_req", {31'b0, ImemReq}, 32'h0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("skid_pcd", PCD, 32'h10);
        check("skid_addr", ImemAddr, 32'h14);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);

        // Redirect while the request at 0x20 is outstanding.
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 32'h100, 0);
        check("drop_addr", ImemAddr, 32'h20);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        check("drop_valid", {31'b0, ValidD}, 32'h0);
        check("drop_target", ImemAddr, 32'h100);

        // Redirect coinciding with a response under decode stall, then in HOLD.
        step(0, 1, 0, 1, 32'h200, 1);
        check("simul_valid", {31'b0, ValidD}, 32'h0);
        check("simul_addr", ImemAddr, 32'h200);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 1, 32'h300, 1);
        check("hold_redir_req", {31'b0, ImemReq}, 32'h1);
        check("hold_redir_addr", ImemAddr, 32'h300);

        // Flush empties the skid buffer.
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0, 0);
        check("flush_addr", ImemAddr, 32'h304);
        check("flush_valid", {31'b0, ValidD}, 32'h0);

        // Wrap-around at the top of the address space.
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("wrap_pcd", PCD, 32'hFFFF_FFFC);
        check("wrap_pc4", PCPlus4D, 32'h0);
        check("wrap_addr", ImemAddr, 32'h0);

        // Asynchronous reset while parked in HOLD.
        step(0, 1, 0, 0, 0, 1);
        StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; ImemValid = 0;
        rst = 1'b0;
        #2;
        modelReset();
        checkOutputs(1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Random stalls, redirects and memory latency.
        memWait = 0;
        for (int i = 0; i < 500; i++) begin
            logic sF, sD, fD, pS, v;
            logic [31:0] tgt;
            sD  = ($urandom_range(0, 3) == 0);
            sF  = sD || ($urandom_range(0, 7) == 0);
            pS  = ($urandom_range(0, 11) == 0);
            fD  = pS && ($urandom_range(0, 1) == 1);
            tgt = 32'($urandom_range(0, 1023)) << 2;
            v   = 1'b0;
            if (expReq()) begin
                if (memWait == 0) begin
                    v = 1'b1;
                    memWait = $urandom_range(0, 3);
                end else memWait--;
            end
            step(sF, sD, fD, pS, tgt, v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
